// File: rtl/autosym_sweep_ctrl.sv
// Sweeps every x in [0, 2^N) through a shared evaluator and checks f(x) == f(x ^ alpha),
// counting the ones of f along the way and stopping at the first asymmetric x.
module autosym_sweep_ctrl #(
    parameter int unsigned N        = 11,
    parameter int unsigned EVAL_LAT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] alpha,
    output logic [N-1:0] eval_x,
    input  logic         eval_y,
    output logic         busy,
    output logic         done,
    output logic         sym_ok,
    output logic [N:0]   ones_cnt,
    output logic [N-1:0] fail_vec
);

    localparam int unsigned CW = N + 1;
    localparam int unsigned LW = 2;

    typedef enum logic [1:0] {IDLE, PH_A, PH_B, DONE} state_t;

    state_t          state_q,    state_d;
    logic [N-1:0]    alpha_q,    alpha_d;
    logic [N-1:0]    x_q,        x_d;
    logic [LW-1:0]   lat_q,      lat_d;
    logic            ya_q,       ya_d;
    logic [N-1:0]    eval_x_q,   eval_x_d;
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;
    logic            sym_ok_q,   sym_ok_d;
    logic [CW-1:0]   ones_cnt_q, ones_cnt_d;
    logic [N-1:0]    fail_vec_q, fail_vec_d;

    logic            phase_end_c;
    logic            x_last_c;

    assign phase_end_c = (lat_q == LW'(EVAL_LAT));
    assign x_last_c    = &x_q;

    // Next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        alpha_d    = alpha_q;
        x_d        = x_q;
        lat_d      = lat_q;
        ya_d       = ya_q;
        eval_x_d   = eval_x_q;
        busy_d     = busy_q;
        done_d     = done_q;
        sym_ok_d   = sym_ok_q;
        ones_cnt_d = ones_cnt_q;
        fail_vec_d = fail_vec_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = PH_A;
                    alpha_d    = alpha;
                    x_d        = '0;
                    lat_d      = '0;
                    eval_x_d   = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    sym_ok_d   = 1'b1;
                    ones_cnt_d = '0;
                    fail_vec_d = '0;
                end
            end
            PH_A: begin
                if (phase_end_c) begin
                    ya_d     = eval_y;
                    lat_d    = '0;
                    state_d  = PH_B;
                    eval_x_d = x_q ^ alpha_q;
                    if (eval_y) begin
                        ones_cnt_d = ones_cnt_q + CW'(1);
                    end
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            PH_B: begin
                if (phase_end_c) begin
                    lat_d = '0;
                    if (eval_y != ya_q) begin
                        // Asymmetry found: abort with the offending x
                        state_d    = DONE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        sym_ok_d   = 1'b0;
                        fail_vec_d = x_q;
                    end else if (x_last_c) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = PH_A;
                        x_d      = x_q + N'(1);
                        eval_x_d = x_q + N'(1);
                    end
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            alpha_q    <= '0;
            x_q        <= '0;
            lat_q      <= '0;
            ya_q       <= 1'b0;
            eval_x_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sym_ok_q   <= 1'b0;
            ones_cnt_q <= '0;
            fail_vec_q <= '0;
        end else begin
            state_q    <= state_d;
            alpha_q    <= alpha_d;
            x_q        <= x_d;
            lat_q      <= lat_d;
            ya_q       <= ya_d;
            eval_x_q   <= eval_x_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sym_ok_q   <= sym_ok_d;
            ones_cnt_q <= ones_cnt_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    assign eval_x   = eval_x_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sym_ok   = sym_ok_q;
    assign ones_cnt = ones_cnt_q;
    assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_autosym_sweep_ctrl.sv
// Bench for autosym_sweep_ctrl: two instances (EVAL_LAT 0 and 2) driven by an x[1]^x[2] evaluator model.
module tb_autosym_sweep_ctrl;

    localparam int unsigned N = 11;

    typedef struct {
        logic          sym;
        logic [N:0]    ones;
        logic [N-1:0]  fail;
        int            done_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start0, start2;
    logic [N-1:0]  alpha0, alpha2;
    logic [N-1:0]  eval_x0, eval_x2;
    logic          eval_y0, eval_y2;
    logic          busy0, busy2, done0, done2, sym0, sym2;
    logic [N:0]    ones0, ones2;
    logic [N-1:0]  fail0, fail2;
    logic [N-1:0]  dly1, dly2;

    int            sel;
    logic [N-1:0]  eval_x_s, fail_s;
    logic          busy_s, done_s, sym_s;
    logic [N:0]    ones_s;

    int            n_checks = 0;
    int            n_fail   = 0;
    exp_t          sb_q[$];

    always #5 clk = ~clk;

    function automatic logic f_model(input logic [N-1:0] x);
        return x[1] ^ x[2];
    endfunction

    assign eval_y0 = f_model(eval_x0);
    always_ff @(posedge clk) begin
        dly1 <= eval_x2;
        dly2 <= dly1;
    end
    assign eval_y2 = f_model(dly2);

    autosym_sweep_ctrl #(.N(N), .EVAL_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .alpha(alpha0), .eval_x(eval_x0),
        .eval_y(eval_y0), .busy(busy0), .done(done0), .sym_ok(sym0),
        .ones_cnt(ones0), .fail_vec(fail0)
    );

    autosym_sweep_ctrl #(.N(N), .EVAL_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .alpha(alpha2), .eval_x(eval_x2),
        .eval_y(eval_y2), .busy(busy2), .done(done2), .sym_ok(sym2),
        .ones_cnt(ones2), .fail_vec(fail2)
    );

    always_comb begin
        if (sel == 2) begin
            eval_x_s = eval_x2; busy_s = busy2; done_s = done2;
            sym_s = sym2; ones_s = ones2; fail_s = fail2;
        end else begin
            eval_x_s = eval_x0; busy_s = busy0; done_s = done0;
            sym_s = sym0; ones_s = ones0; fail_s = fail0;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input int lat, input logic s, input logic [N-1:0] a);
        if (lat == 2) begin
            start2 = s; alpha2 = a;
        end else begin
            start0 = s; alpha0 = a;
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the first DONE cycle.
    task automatic sweep(input int lat, input logic [N-1:0] a, input int mid_start,
                         input int rst_at, input int hold);
        exp_t e;
        int   cyc;
        int   idx;
        logic [N-1:0] ex;
        logic [N-1:0] v;
        logic ya, yb;

        sel = lat;
        e.sym = 1'b1; e.ones = '0; e.fail = '0; e.done_cyc = 0;
        for (int x = 0; x < (1 << N); x++) begin
            v  = N'(x);
            ya = f_model(v);
            yb = f_model(v ^ a);
            if (ya) e.ones = e.ones + (N+1)'(1);
            e.done_cyc = (x + 1) * 2 * (lat + 1) + 1;
            if (ya != yb) begin
                e.sym  = 1'b0;
                e.fail = v;
                break;
            end
        end
        if (rst_at == 0) sb_q.push_back(e);

        drive(lat, 1'b1, a);
        @(negedge clk);
        cyc = 1;
        forever begin
            drive(lat, 1'b0, ~a);
            if (cyc == mid_start) drive(lat, 1'b1, N'($urandom));
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check("rst_busy", 32'(busy_s), 32'd0);
                check("rst_done", 32'(done_s), 32'd0);
                check("rst_eval_x", 32'(eval_x_s), 32'd0);
                check("rst_sym_ok", 32'(sym_s), 32'd0);
                check("rst_ones", 32'(ones_s), 32'd0);
                check("rst_fail_vec", 32'(fail_s), 32'd0);
                @(negedge clk);
                check("rst_stays_idle", 32'(busy_s), 32'd0);
                return;
            end
            if (cyc == 1) begin
                check("start_busy", 32'(busy_s), 32'd1);
                check("start_done", 32'(done_s), 32'd0);
                check("start_ones_clr", 32'(ones_s), 32'd0);
                check("start_sym_set", 32'(sym_s), 32'd1);
                check("start_fail_clr", 32'(fail_s), 32'd0);
            end
            if (done_s) begin
                check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                check("done_busy", 32'(busy_s), 32'd0);
                break;
            end
            idx = (cyc - 1) / (lat + 1);
            ex  = N'(idx / 2);
            if (idx % 2 == 1) ex = ex ^ a;
            check("eval_x", 32'(eval_x_s), 32'(ex));
            check("busy", 32'(busy_s), 32'd1);
            if (cyc > 20000) begin
                check("done_timeout", 32'(done_s), 32'd1);
                break;
            end
            @(negedge clk);
            cyc++;
        end

        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("sym_ok", 32'(sym_s), 32'(e.sym));
            check("ones_cnt", 32'(ones_s), 32'(e.ones));
            check("fail_vec", 32'(fail_s), 32'(e.fail));
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_done", 32'(done_s), 32'd1);
            check("hold_sym_ok", 32'(sym_s), 32'(e.sym));
            check("hold_ones", 32'(ones_s), 32'(e.ones));
            check("hold_fail", 32'(fail_s), 32'(e.fail));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sel = 0;
        start0 = 1'b0; start2 = 1'b0;
        alpha0 = '0;   alpha2 = '0;
        repeat (3) @(negedge clk);
        check("por_busy", 32'(busy_s), 32'd0);
        check("por_done", 32'(done_s), 32'd0);
        check("por_sym_ok", 32'(sym_s), 32'd0);
        check("por_ones", 32'(ones_s), 32'd0);
        check("por_eval_x", 32'(eval_x_s), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        sweep(0, 11'h006, 100, 0, 3);
        repeat (2) @(negedge clk);
        sweep(0, 11'h002, 0, 0, 2);
        repeat (2) @(negedge clk);
        sweep(0, 11'h000, 0, 0, 0);
        repeat (2) @(negedge clk);
        sweep(2, 11'h400, 0, 0, 1);
        repeat (2) @(negedge clk);
        sweep(0, 11'h006, 0, 500, 0);
        repeat (2) @(negedge clk);
        sweep(0, 11'h006, 0, 0, 0);
        sweep(0, 11'h006, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
